// File: rtl/psum_pingpong_buf.sv
// Ping-pong partial-sum buffer: INIT/ACC passes fill the idle bank (optionally adding the
// live bank), DUMP streams the live bank out with optional ReLU; banks swap after each fill.
module psum_pingpong_buf #(
    parameter int NUM_CH   = 8,
    parameter int PSUM_BW  = 32,
    parameter int DEPTH    = 16,
    parameter int SATURATE = 1,
    parameter int AW       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [AW:0]               len,
    input  logic                      relu_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*PSUM_BW-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*PSUM_BW-1:0] out_data,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_bank,
    output logic                      start_err
);

    localparam int              VW        = NUM_CH * PSUM_BW;
    localparam logic [AW:0]     DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW:0]     LEN_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [1:0]      MODE_ACC  = 2'd1;
    localparam logic [1:0]      MODE_DUMP = 2'd2;
    localparam logic [1:0]      MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DUMP, S_DONE} state_t;

    state_t          state_reg;
    logic [1:0]      mode_reg;
    logic [AW:0]     len_reg;
    logic            relu_reg;
    logic [AW-1:0]   wptr_reg;
    logic [AW-1:0]   rptr_reg;
    logic            dump_last_reg;

    logic [VW-1:0]   bank_mem [2][DEPTH];

    logic [AW:0]     last_idx;
    logic            wr_last;
    logic            rd_last;
    logic            wr_en;
    logic [VW-1:0]   old_vec;
    logic [VW-1:0]   acc_vec;
    logic [VW-1:0]   wr_vec;
    logic [VW-1:0]   rd_vec;
    logic [VW-1:0]   relu_vec;

    assign last_idx = len_reg - LEN_ONE;
    assign wr_last  = ({1'b0, wptr_reg} == last_idx);
    assign rd_last  = ({1'b0, rptr_reg} == last_idx);
    assign wr_en    = (state_reg == S_FILL) && in_valid && in_ready;

    // ACC reads the live bank at the write index in the same cycle, so no extra latency.
    assign old_vec  = bank_mem[rd_bank][wptr_reg];
    assign rd_vec   = bank_mem[rd_bank][rptr_reg];
    assign wr_vec   = (mode_reg == MODE_ACC) ? acc_vec : in_data;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [PSUM_BW-1:0] a_ch;
            logic [PSUM_BW-1:0] b_ch;
            logic [PSUM_BW:0]   sum_ch;

            assign a_ch   = old_vec[gi*PSUM_BW +: PSUM_BW];
            assign b_ch   = in_data[gi*PSUM_BW +: PSUM_BW];
            assign sum_ch = {a_ch[PSUM_BW-1], a_ch} + {b_ch[PSUM_BW-1], b_ch};

            if (SATURATE != 0) begin : g_sat
                // Overflow shows as disagreement between the extra sign bit and the result MSB.
                assign acc_vec[gi*PSUM_BW +: PSUM_BW] =
                    (sum_ch[PSUM_BW] == sum_ch[PSUM_BW-1]) ? sum_ch[PSUM_BW-1:0] :
                    sum_ch[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} :
                                      {1'b0, {(PSUM_BW-1){1'b1}}};
            end else begin : g_wrap
                assign acc_vec[gi*PSUM_BW +: PSUM_BW] = sum_ch[PSUM_BW-1:0];
            end

            assign relu_vec[gi*PSUM_BW +: PSUM_BW] =
                (relu_reg && rd_vec[gi*PSUM_BW + PSUM_BW - 1]) ? '0 : rd_vec[gi*PSUM_BW +: PSUM_BW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_mem[~rd_bank][wptr_reg] <= wr_vec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            mode_reg      <= 2'd0;
            len_reg       <= '0;
            relu_reg      <= 1'b0;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            dump_last_reg <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_bank       <= 1'b0;
            start_err     <= 1'b0;
        end else begin
            done      <= 1'b0;
            start_err <= start && (state_reg != S_IDLE);
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (mode == MODE_RSVD || len > DEPTH_L) begin
                            start_err <= 1'b1;
                        end else begin
                            mode_reg      <= mode;
                            len_reg       <= len;
                            relu_reg      <= relu_en;
                            wptr_reg      <= '0;
                            rptr_reg      <= '0;
                            dump_last_reg <= 1'b0;
                            out_valid     <= 1'b0;
                            busy          <= 1'b1;
                            if (len == '0) begin
                                state_reg <= S_DONE;
                                done      <= 1'b1;
                            end else if (mode == MODE_DUMP) begin
                                state_reg <= S_DUMP;
                            end else begin
                                state_reg <= S_FILL;
                                in_ready  <= 1'b1;
                            end
                        end
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        if (wr_last) begin
                            in_ready  <= 1'b0;
                            rd_bank   <= ~rd_bank;
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            wptr_reg <= wptr_reg + PTR_ONE;
                        end
                    end
                end
                S_DUMP: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && dump_last_reg) begin
                            out_valid     <= 1'b0;
                            dump_last_reg <= 1'b0;
                            state_reg     <= S_DONE;
                            done          <= 1'b1;
                        end else begin
                            out_data      <= relu_vec;
                            out_valid     <= 1'b1;
                            dump_last_reg <= rd_last;
                            if (!rd_last) begin
                                rptr_reg <= rptr_reg + PTR_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_pingpong_buf.sv
// Bench for psum_pingpong_buf: a saturating and a wrapping instance share stimulus and are
// compared against a per-bank array model computed with plain integer arithmetic.
module tb_psum_pingpong_buf;

    localparam int NUM_CH  = 8;
    localparam int PSUM_BW = 32;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int VW      = NUM_CH * PSUM_BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [AW:0]   len;
    logic          relu_en;
    logic          in_valid;
    logic [VW-1:0] in_data;
    logic          out_ready;

    logic          in_ready, out_valid, busy, done, rd_bank, start_err;
    logic [VW-1:0] out_data;
    logic          w_in_ready, w_out_valid, w_busy, w_done, w_rd_bank, w_start_err;
    logic [VW-1:0] w_out_data;

    psum_pingpong_buf #(.NUM_CH(NUM_CH), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH), .SATURATE(1), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .rd_bank(rd_bank), .start_err(start_err)
    );

    psum_pingpong_buf #(.NUM_CH(NUM_CH), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH), .SATURATE(0), .AW(AW)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .busy(w_busy), .done(w_done), .rd_bank(w_rd_bank), .start_err(w_start_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: logical contents of each bank per channel, plus the live bank index.
    int            ref_s [2][DEPTH][NUM_CH];
    int            ref_w [2][DEPTH][NUM_CH];
    bit            ref_rd;
    logic [VW-1:0] stim [DEPTH];

    typedef struct {
        logic [1:0]  m;
        logic [AW:0] l;
        bit          exp_err;
        bit          exp_done;
    } edge_t;
    edge_t etab [6];

    task automatic check_v(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_b(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_i(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int acc_fn(input int a, input int b, input bit sat);
        longint s;
        s = longint'(a) + longint'(b);
        if (sat) begin
            if (s > 64'sd2147483647)  s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
        end
        return int'(s);
    endfunction

    function automatic logic [VW-1:0] exp_vec(input bit b, input int idx, input bit relu, input bit wrap);
        logic [VW-1:0] r;
        int x;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            x = wrap ? ref_w[b][idx][c] : ref_s[b][idx][c];
            if (relu && x < 0) x = 0;
            r[c*PSUM_BW +: PSUM_BW] = x;
        end
        return r;
    endfunction

    task automatic stim_random();
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < NUM_CH; c++)
                stim[i][c*PSUM_BW +: PSUM_BW] = $urandom;
    endtask

    task automatic fill_pass(input logic [1:0] m, input int n, input bit gaps, input int poke_at);
        int  i, cyc, b;
        bit  rdy, poke_check, wb;
        @(negedge clk);
        start = 1'b1; mode = m; len = n[AW:0]; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_b("fill_busy", busy, 1'b1);
        check_b("fill_in_ready", in_ready, 1'b1);
        i = 0; cyc = 0; poke_check = 0;
        wb = ~ref_rd;
        while (i < n && cyc < 200) begin
            if (i == poke_at && !poke_check) begin
                start = 1'b1; mode = 2'd3; poke_check = 1;
            end
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = stim[i];
            rdy      = in_ready;
            @(posedge clk);
            if (in_valid && rdy) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    b = stim[i][c*PSUM_BW +: PSUM_BW];
                    if (m == 2'd0) begin
                        ref_s[wb][i][c] = b;
                        ref_w[wb][i][c] = b;
                    end else begin
                        ref_s[wb][i][c] = acc_fn(ref_s[ref_rd][i][c], b, 1'b1);
                        ref_w[wb][i][c] = acc_fn(ref_w[ref_rd][i][c], b, 1'b0);
                    end
                end
                i++;
            end
            @(negedge clk);
            cyc++;
            if (start) begin
                start = 1'b0;
                check_b("start_err_during_fill", start_err, 1'b1);
            end
        end
        in_valid = 1'b0;
        ref_rd = wb;
        check_i("fill_beats", i, n);
        check_b("fill_done", done, 1'b1);
        check_b("fill_in_ready_drop", in_ready, 1'b0);
        check_b("fill_rd_bank", rd_bank, ref_rd);
        @(negedge clk);
        check_b("fill_done_pulse_end", done, 1'b0);
        check_b("fill_idle_busy", busy, 1'b0);
        $display("fill mode=%0d len=%0d rd_bank=%0d", m, n, rd_bank);
    endtask

    // rmode: 0 = out_ready held high, 1 = 1,0,0,1 pattern, 2 = random
    task automatic dump_pass(input int n, input bit relu, input int rmode);
        int            k, cyc, phase, early_done;
        bit            prev_v, prev_r;
        logic [VW-1:0] prev_d;
        bit            pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        start = 1'b1; mode = 2'd2; len = n[AW:0]; relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        check_b("dump_busy", busy, 1'b1);
        k = 0; cyc = 0; phase = 0; early_done = 0; prev_v = 0; prev_r = 0; prev_d = '0;
        while (k < n && cyc < 400) begin
            if (prev_v && !prev_r) begin
                check_b("stall_valid", out_valid, 1'b1);
                check_v("stall_data", out_data, prev_d);
            end
            if (done) early_done++;
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[phase % 4] : 1'($urandom_range(0, 1));
            phase++;
            prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
            if (out_valid && out_ready) begin
                check_v("dump_data_sat", out_data, exp_vec(ref_rd, k, relu, 1'b0));
                check_v("dump_data_wrap", w_out_data, exp_vec(ref_rd, k, relu, 1'b1));
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check_i("dump_count", k, n);
        check_i("dump_early_done", early_done, 0);
        check_b("dump_done", done, 1'b1);
        check_b("dump_valid_drop", out_valid, 1'b0);
        check_b("dump_rd_bank_kept", rd_bank, ref_rd);
        @(negedge clk);
        check_b("dump_done_pulse_end", done, 1'b0);
        check_b("dump_idle_busy", busy, 1'b0);
        $display("dump len=%0d relu=%0d ready_mode=%0d vectors=%0d", n, relu, rmode, k);
    endtask

    initial begin
        etab[0] = '{m: 2'd3, l: 5'd4,  exp_err: 1'b1, exp_done: 1'b0};
        etab[1] = '{m: 2'd0, l: 5'd17, exp_err: 1'b1, exp_done: 1'b0};
        etab[2] = '{m: 2'd2, l: 5'd31, exp_err: 1'b1, exp_done: 1'b0};
        etab[3] = '{m: 2'd0, l: 5'd0,  exp_err: 1'b0, exp_done: 1'b1};
        etab[4] = '{m: 2'd2, l: 5'd0,  exp_err: 1'b0, exp_done: 1'b1};
        etab[5] = '{m: 2'd3, l: 5'd0,  exp_err: 1'b1, exp_done: 1'b0};

        reset = 1'b1; start = 1'b0; mode = 2'd0; len = '0; relu_en = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ref_rd = 1'b0;
        repeat (3) @(negedge clk);
        check_b("rst_in_ready", in_ready, 1'b0);
        check_b("rst_out_valid", out_valid, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_done", done, 1'b0);
        check_b("rst_start_err", start_err, 1'b0);
        check_b("rst_rd_bank", rd_bank, 1'b0);
        check_v("rst_out_data", out_data, '0);
        reset = 1'b0;
        @(negedge clk);

        // Start-condition table: illegal starts pulse start_err, len 0 goes straight to done.
        for (int t = 0; t < 6; t++) begin
            start = 1'b1; mode = etab[t].m; len = etab[t].l;
            @(negedge clk);
            start = 1'b0;
            check_b("tab_start_err", start_err, etab[t].exp_err);
            check_b("tab_done", done, etab[t].exp_done);
            check_b("tab_busy", busy, etab[t].exp_done);
            check_b("tab_rd_bank", rd_bank, ref_rd);
            @(negedge clk);
            check_b("tab_idle_busy", busy, 1'b0);
            check_b("tab_err_end", start_err, 1'b0);
            $display("table row %0d mode=%0d len=%0d start_err=%0d", t, etab[t].m, etab[t].l, etab[t].exp_err);
        end

        // INIT 100*i+c, then dump with full throughput.
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < NUM_CH; c++)
                stim[i][c*PSUM_BW +: PSUM_BW] = 100 * i + c;
        fill_pass(2'd0, 16, 1'b0, -1);
        check_b("init_swap_to_1", rd_bank, 1'b1);
        dump_pass(16, 1'b0, 0);

        // INIT then ACC with i+c, dump under the 1,0,0,1 ready pattern.
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < NUM_CH; c++)
                stim[i][c*PSUM_BW +: PSUM_BW] = i + c;
        fill_pass(2'd0, 16, 1'b0, -1);
        fill_pass(2'd1, 16, 1'b1, -1);
        dump_pass(16, 1'b0, 1);

        // Saturation corner: 0x7FFFFFF0 + 0x20.
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < NUM_CH; c++)
                stim[i][c*PSUM_BW +: PSUM_BW] = 32'h7FFF_FFF0;
        fill_pass(2'd0, 4, 1'b0, -1);
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < NUM_CH; c++)
                stim[i][c*PSUM_BW +: PSUM_BW] = 32'h0000_0020;
        fill_pass(2'd1, 4, 1'b0, -1);
        check_i("sat_model_ch0", ref_s[ref_rd][0][0], 32'h7FFF_FFFF);
        check_i("wrap_model_ch0", ref_w[ref_rd][0][0], 32'h8000_0010);
        dump_pass(4, 1'b0, 0);

        // ReLU on -5 / 7, then the same bank dumped again without ReLU.
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < NUM_CH; c++)
                stim[i][c*PSUM_BW +: PSUM_BW] = (c % 2 == 0) ? -32'sd5 : 32'sd7;
        fill_pass(2'd0, 4, 1'b0, -1);
        dump_pass(4, 1'b1, 2);
        dump_pass(4, 1'b0, 2);

        // Illegal start in the middle of a fill must not disturb the pass.
        stim_random();
        fill_pass(2'd0, 8, 1'b1, 3);
        dump_pass(8, 1'b0, 2);

        // Reset at beat 7 of an INIT pass.
        stim_random();
        @(negedge clk);
        start = 1'b1; mode = 2'd0; len = 5'd16;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = stim[i];
            @(negedge clk);
        end
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check_b("midrst_busy", busy, 1'b0);
        check_b("midrst_in_ready", in_ready, 1'b0);
        check_b("midrst_rd_bank", rd_bank, 1'b0);
        check_b("midrst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0; ref_rd = 1'b0;
        @(negedge clk);
        check_b("midrst_no_done", done, 1'b0);
        $display("reset at beat 7 applied");

        // Re-establish both banks, then random passes against the model.
        stim_random();
        fill_pass(2'd0, 16, 1'b1, -1);
        stim_random();
        fill_pass(2'd0, 16, 1'b1, -1);
        for (int r = 0; r < 30; r++) begin
            int m, n;
            m = $urandom_range(0, 2);
            n = $urandom_range(1, DEPTH);
            if (m == 2) begin
                dump_pass(n, 1'($urandom_range(0, 1)), 2);
            end else begin
                stim_random();
                fill_pass(m[1:0], n, 1'b1, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_pingpong_buf.md
Name: psum_pingpong_buf

Overview:
- Parametrised ping-pong partial-sum buffer for the systolic array output path.
- Replaces the fixed two-bank psum SRAM control in the core with one self-contained block:
  - two banks of DEPTH x NUM_CH x PSUM_BW;
  - an INIT pass writes fresh psums;
  - an ACC pass reads the old bank, adds the incoming vector and writes the other bank;
  - a DUMP pass streams the final bank out with optional ReLU.
- Bank swap is automatic after every INIT/ACC pass.
- Sits between the corelet OFIFO/SFU output and the top-level result port.

Parameters:
- NUM_CH, 8, channels (MAC columns) per vector
- PSUM_BW, 32, bits per channel psum (signed)
- DEPTH, 16, entries per bank (len_nij)
- SATURATE, 1, 1 = clamp ACC sums to signed PSUM_BW range; 0 = two's-complement wrap
- AW, 4, address width, clog2(DEPTH)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pass start, sampled only in IDLE
- mode  in  2  latched at start: 0 = INIT, 1 = ACC, 2 = DUMP, 3 = reserved
- len  in  AW+1  entries in pass, 0..DEPTH, latched at start
- relu_en  in  1  latched at start; DUMP clamps negative channels to 0
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts input
- in_data  in  NUM_CH*PSUM_BW  input psum vector, channel c at bits [c*PSUM_BW +: PSUM_BW]
- out_valid  out  1  dump vector valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_CH*PSUM_BW  dump vector
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at pass end
- rd_bank  out  1  bank holding the latest complete result
- start_err  out  1  one-cycle pulse on illegal start

Behaviour:
- States: IDLE, FILL (INIT/ACC), DUMP, DONE.
- Reset values:
  - state = IDLE;
  - in_ready, out_valid, busy, done, start_err = 0;
  - rd_bank = 0; pointers = 0; out_data = 0.
  - Bank contents are not reset.
- IDLE:
  - start with mode 0/1 and len 1..DEPTH -> FILL.
  - start with mode 2 and len 1..DEPTH -> DUMP.
  - start with len 0 -> DONE; no swap, no transfers.
  - start with mode 3 or len > DEPTH -> start_err pulse next cycle; remain IDLE.
- Start while busy: ignored, start_err pulse.
- FILL:
  - in_ready = 1. Each in_valid & in_ready beat writes bank ~rd_bank at wptr, then wptr++.
  - INIT writes in_data directly.
  - ACC writes bank[rd_bank][wptr] + in_data per channel, read combinationally at the same index. Zero extra latency.
  - Per-channel signed add, PSUM_BW+1-bit intermediate:
    - SATURATE = 1: clamp to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].
    - SATURATE = 0: truncate.
  - After the beat with wptr == len-1: in_ready drops the next cycle, rd_bank toggles, go to DONE.
- DUMP:
  - Reads bank rd_bank at rptr 0..len-1 into the out_data register.
  - out_data/out_valid load when !out_valid | out_ready. First out_valid one cycle after entering DUMP.
  - Holding rule: out_data and out_valid stay stable while out_valid & !out_ready.
  - Full throughput (one vector per cycle) when out_ready is held high.
  - relu_en applies per channel at register load.
  - After the handshake of entry len-1: out_valid = 0, go to DONE. rd_bank unchanged, so a dump can repeat.
- DONE: done = 1 for exactly one cycle, then IDLE. busy = 0 in the IDLE cycle after done.
- DEPTH boundary: pointers never exceed len-1; no wrap within a pass; both pointers clear at every start.
- Reset mid-pass: immediate return to IDLE; rd_bank = 0; no done; partially written bank content is undefined.
- in_valid outside FILL: ignored. out_ready outside DUMP: ignored.

Test Plan:
- INIT pass, len=16, ch c of entry i = 100*i + c -> done after the 16th beat; rd_bank 0 -> 1; DUMP returns identical 16 vectors in order.
- INIT then ACC, both with in_data = i + c -> DUMP yields 2*(i + c); rd_bank returns to 0.
- SATURATE=1: INIT 0x7FFFFFF0, then ACC +0x20 -> dump 0x7FFFFFFF. Repeat with SATURATE=0 -> 0x80000010.
- DUMP with relu_en=1 on channels holding -5 and 7 -> outputs 0 and 7.
- DUMP with out_ready toggled 1,0,0,1:
  - out_data stable while stalled;
  - 16 vectors, no drops, no duplicates;
  - done only after the 16th handshake.
- Edge cases:
  - start len=0 -> done next cycle, rd_bank unchanged.
  - start mode=3 -> start_err pulse, stays IDLE.
  - start during FILL -> start_err, pass unaffected.
  - reset asserted at beat 7 -> IDLE, busy=0, rd_bank=0.
